// File: rtl/perf_counter_unit.sv
// perf_counter_unit: programmable event counters with
// Wishbone access, overflow status and interrupt.
module perf_counter_unit #(
  parameter int NUM_CTR    = 4,
  parameter int CTR_WIDTH  = 64,
  parameter int NUM_EVENTS = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            wb_adr_i,
  input  logic [31:0]           wb_dat_i,
  output logic [31:0]           wb_dat_o,
  input  logic                  wb_we_i,
  input  logic [3:0]            wb_sel_i,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  output logic                  wb_ack_o,
  input  logic [NUM_EVENTS-1:0] events_i,
  output logic                  irq_o
);

  localparam int HW = CTR_WIDTH - 32;

  typedef logic [CTR_WIDTH-1:0] ctr_t;

  logic               ack_q;
  logic [31:0]        dat_q;
  logic               irq_q;
  logic               gen_q;
  logic               frz_q;
  logic [NUM_CTR-1:0] ovf_q;
  logic [NUM_CTR-1:0] ien_q;
  logic [NUM_CTR-1:0] en_q;
  logic [NUM_CTR-1:0] mode_q;
  logic [4:0]         sel_q [NUM_CTR];
  ctr_t               ctr_q [NUM_CTR];
  ctr_t               ctr_d [NUM_CTR];
  logic [HW-1:0]      snap_q;
  logic [HW-1:0]      snap_d;
  logic [31:0]        evq_q;
  logic [31:0]        ev_all;

  logic               acc;
  logic               wr;
  logic               rd;
  logic [3:0]         blk;
  logic [3:0]         cnum;
  logic [2:0]         cidx;
  logic [1:0]         off;
  logic               ctr_hit;
  logic               is_ctrl;
  logic               is_ovf;
  logic               is_ien;
  logic               wr_ctrl;
  logic               wr_ien;
  logic               clr;
  logic [NUM_CTR-1:0] ovf_clr;
  logic [NUM_CTR-1:0] wr_cfg;
  logic [NUM_CTR-1:0] wr_lo;
  logic [NUM_CTR-1:0] wr_hi;
  logic [NUM_CTR-1:0] inc;
  logic [NUM_CTR-1:0] wrap;
  logic [31:0]        rdata;
  logic               unused_adr;

  function automatic logic [31:0] merge(
    input logic [31:0] o,
    input logic [31:0] d,
    input logic [3:0]  be
  );
    logic [31:0] r;
    for (int b = 0; b < 4; b++) begin
      r[8*b +: 8] = be[b] ? d[8*b +: 8] : o[8*b +: 8];
    end
    return r;
  endfunction

  assign unused_adr = ^wb_adr_i[1:0];

  // an access starts only when no ack is pending,
  // so a held strobe is acked every other cycle
  assign acc = wb_cyc_i & wb_stb_i & ~ack_q;
  assign wr  = acc & wb_we_i;
  assign rd  = acc & ~wb_we_i;

  assign blk  = wb_adr_i[7:4];
  assign off  = wb_adr_i[3:2];
  assign cnum = blk - 4'd4;
  assign cidx = cnum[2:0];

  assign ctr_hit = (blk[3:2] != 2'b00) &&
                   ({28'd0, cnum} < NUM_CTR);

  assign is_ctrl = (wb_adr_i[7:2] == 6'd0);
  assign is_ovf  = (wb_adr_i[7:2] == 6'd1);
  assign is_ien  = (wb_adr_i[7:2] == 6'd2);

  assign wr_ctrl = wr & is_ctrl & wb_sel_i[0];
  assign wr_ien  = wr & is_ien & wb_sel_i[0];
  assign clr     = wr_ctrl & wb_dat_i[1];
  assign ovf_clr = (wr & is_ovf & wb_sel_i[0]) ?
                   wb_dat_i[NUM_CTR-1:0] : '0;

  // per-counter register write strobes
  always_comb begin
    wr_cfg = '0;
    wr_lo  = '0;
    wr_hi  = '0;
    for (int i = 0; i < NUM_CTR; i++) begin
      if (wr && ctr_hit && cidx == 3'(i)) begin
        wr_cfg[i] = (off == 2'd0);
        wr_lo[i]  = (off == 2'd1);
        wr_hi[i]  = (off == 2'd2);
      end
    end
  end

  // event vector; select 31 is the constant-one source
  always_comb begin
    ev_all = '0;
    ev_all[NUM_EVENTS-1:0] = events_i;
    ev_all[31] = 1'b1;
  end

  // counter next value: clear, then bus write, then count
  always_comb begin
    logic [63:0] w;
    logic        cond;
    w    = '0;
    cond = 1'b0;
    for (int i = 0; i < NUM_CTR; i++) begin
      w = '0;
      w[CTR_WIDTH-1:0] = ctr_q[i];
      if (wr_lo[i]) begin
        w[31:0] = merge(w[31:0], wb_dat_i, wb_sel_i);
      end
      if (wr_hi[i]) begin
        w[63:32] = merge(w[63:32], wb_dat_i, wb_sel_i);
      end
      cond = mode_q[i] ?
             (ev_all[sel_q[i]] & ~evq_q[sel_q[i]]) :
             ev_all[sel_q[i]];
      inc[i]  = gen_q & en_q[i] & cond;
      wrap[i] = 1'b0;
      if (clr) begin
        ctr_d[i] = '0;
      end else if (wr_lo[i] | wr_hi[i]) begin
        ctr_d[i] = w[CTR_WIDTH-1:0];
      end else if (inc[i]) begin
        ctr_d[i] = ctr_q[i] + ctr_t'(1);
        wrap[i]  = &ctr_q[i];
      end else begin
        ctr_d[i] = ctr_q[i];
      end
    end
  end

  // read mux; an LO read also captures the upper half
  always_comb begin
    rdata  = '0;
    snap_d = snap_q;
    unique case (1'b1)
      is_ctrl: rdata = {29'd0, frz_q, 1'b0, gen_q};
      is_ovf:  rdata[NUM_CTR-1:0] = ovf_q;
      is_ien:  rdata[NUM_CTR-1:0] = ien_q;
      ctr_hit: begin
        for (int i = 0; i < NUM_CTR; i++) begin
          if (cidx == 3'(i)) begin
            case (off)
              2'd0: rdata = {22'd0, mode_q[i], en_q[i],
                             3'd0, sel_q[i]};
              2'd1: begin
                rdata = ctr_q[i][31:0];
                if (rd) begin
                  snap_d = ctr_q[i][CTR_WIDTH-1:32];
                end
              end
              2'd2: rdata[HW-1:0] = snap_q;
              default: ;
            endcase
          end
        end
      end
      default: ;
    endcase
  end

  // bus handshake, read data, snapshot, event history, irq
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q  <= 1'b0;
      dat_q  <= '0;
      snap_q <= '0;
      evq_q  <= '0;
      irq_q  <= 1'b0;
    end else begin
      ack_q  <= acc;
      dat_q  <= rd ? rdata : '0;
      snap_q <= snap_d;
      evq_q  <= ev_all;
      irq_q  <= |(ovf_q & ien_q);
    end
  end

  // global control and overflow status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gen_q <= 1'b0;
      frz_q <= 1'b0;
      ovf_q <= '0;
      ien_q <= '0;
    end else begin
      if (wr_ctrl) begin
        gen_q <= wb_dat_i[0];
        frz_q <= wb_dat_i[2];
      end
      if (frz_q && (|wrap)) begin
        gen_q <= 1'b0;
      end
      ovf_q <= (ovf_q & ~ovf_clr) | wrap;
      if (wr_ien) begin
        ien_q <= wb_dat_i[NUM_CTR-1:0];
      end
    end
  end

  // per-counter configuration and count state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q   <= '0;
      mode_q <= '0;
      for (int i = 0; i < NUM_CTR; i++) begin
        sel_q[i] <= '0;
        ctr_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CTR; i++) begin
        if (wr_cfg[i] && wb_sel_i[0]) begin
          sel_q[i] <= wb_dat_i[4:0];
        end
        if (wr_cfg[i] && wb_sel_i[1]) begin
          en_q[i]   <= wb_dat_i[8];
          mode_q[i] <= wb_dat_i[9];
        end
        ctr_q[i] <= ctr_d[i];
      end
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;
  assign irq_o    = irq_q;

endmodule

// File: tb/tb_perf_counter_unit.sv
// tb_perf_counter_unit: random and directed bus traffic
// against a behavioural model with a read-data scoreboard.
module tb_perf_counter_unit;

  localparam int NC = 4;
  localparam int CW = 64;
  localparam int NE = 16;
  localparam longint unsigned MAXV =
    64'hFFFF_FFFF_FFFF_FFFF >> (64 - CW);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    wb_adr_i;
  logic [31:0]   wb_dat_i;
  logic [31:0]   wb_dat_o;
  logic          wb_we_i;
  logic [3:0]    wb_sel_i;
  logic          wb_cyc_i;
  logic          wb_stb_i;
  logic          wb_ack_o;
  logic [NE-1:0] events_i;
  logic          irq_o;

  int checks = 0;
  int errors = 0;
  bit rand_ev = 1'b0;

  logic [31:0] exp_q[$];

  bit              m_gen, m_frz, m_ack, m_irq;
  bit [NC-1:0]     m_ovf, m_ien;
  int              m_sel [NC];
  bit              m_en [NC];
  bit              m_mode [NC];
  longint unsigned m_ctr [NC];
  longint unsigned m_snap;
  bit [31:0]       m_prev;

  always #5 clk = ~clk;

  perf_counter_unit #(
    .NUM_CTR(NC), .CTR_WIDTH(CW), .NUM_EVENTS(NE)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
    .wb_dat_o(wb_dat_o), .wb_we_i(wb_we_i),
    .wb_sel_i(wb_sel_i), .wb_cyc_i(wb_cyc_i),
    .wb_stb_i(wb_stb_i), .wb_ack_o(wb_ack_o),
    .events_i(events_i), .irq_o(irq_o)
  );

  function automatic void model_reset();
    m_gen = 0; m_frz = 0; m_ack = 0; m_irq = 0;
    m_ovf = '0; m_ien = '0; m_snap = 0; m_prev = '0;
    for (int i = 0; i < NC; i++) begin
      m_sel[i] = 0; m_en[i] = 0; m_mode[i] = 0;
      m_ctr[i] = 0;
    end
  endfunction

  function automatic logic [31:0] model_read(
    input logic [7:0] a
  );
    logic [31:0] r;
    int blk, off, idx;
    blk = a[7:4];
    off = a[3:2];
    idx = blk - 4;
    r = '0;
    if (blk == 0) begin
      if (off == 0) r = {29'd0, m_frz, 1'b0, m_gen};
      if (off == 1) r = 32'(m_ovf);
      if (off == 2) r = 32'(m_ien);
    end else if (blk >= 4 && idx < NC) begin
      if (off == 0)
        r = (32'(m_mode[idx]) << 9) |
            (32'(m_en[idx]) << 8) | 32'(m_sel[idx]);
      if (off == 1) r = m_ctr[idx][31:0];
      if (off == 2) r = m_snap[31:0];
    end
    return r;
  endfunction

  function automatic longint unsigned bwrite(
    input longint unsigned v, input bit hi,
    input logic [31:0] d, input logic [3:0] be
  );
    for (int b = 0; b < 4; b++) begin
      if (be[b]) begin
        int p;
        p = (hi ? 32 : 0) + 8 * b;
        v[p +: 8] = d[8*b +: 8];
      end
    end
    return v & MAXV;
  endfunction

  // one clock edge of the reference behaviour
  function automatic void model_step();
    bit acc, wr, rd, clr, ofrz, nirq, cnt, wio;
    bit [NC-1:0] wrapped;
    bit [31:0] ev;
    logic [31:0] rv;
    int blk, off, idx;
    bit hit;
    acc = wb_cyc_i && wb_stb_i && !m_ack;
    wr = acc && wb_we_i;
    rd = acc && !wb_we_i;
    blk = wb_adr_i[7:4];
    off = wb_adr_i[3:2];
    idx = blk - 4;
    hit = blk >= 4 && idx < NC;
    rv = model_read(wb_adr_i);
    for (int s = 0; s < 32; s++) begin
      if (s == 31) ev[s] = 1'b1;
      else if (s < NE) ev[s] = events_i[s];
      else ev[s] = 1'b0;
    end
    if (rd && hit && off == 1) m_snap = m_ctr[idx] >> 32;
    nirq = |(m_ovf & m_ien);
    clr = wr && blk == 0 && off == 0 &&
          wb_sel_i[0] && wb_dat_i[1];
    wrapped = '0;
    for (int i = 0; i < NC; i++) begin
      wio = wr && hit && idx == i && (off == 1 || off == 2);
      cnt = m_gen && m_en[i] &&
            (m_mode[i] ? (ev[m_sel[i]] && !m_prev[m_sel[i]])
                       : ev[m_sel[i]]);
      if (clr) m_ctr[i] = 0;
      else if (wio)
        m_ctr[i] = bwrite(m_ctr[i], off == 2, wb_dat_i, wb_sel_i);
      else if (cnt) begin
        if (m_ctr[i] == MAXV) begin
          m_ctr[i] = 0;
          wrapped[i] = 1'b1;
        end else m_ctr[i] = m_ctr[i] + 1;
      end
    end
    ofrz = m_frz;
    if (wr && blk == 0 && off == 0 && wb_sel_i[0]) begin
      m_gen = wb_dat_i[0];
      m_frz = wb_dat_i[2];
    end
    if (ofrz && wrapped != 0) m_gen = 0;
    if (wr && blk == 0 && off == 1 && wb_sel_i[0])
      m_ovf = m_ovf & ~wb_dat_i[NC-1:0];
    m_ovf = m_ovf | wrapped;
    if (wr && blk == 0 && off == 2 && wb_sel_i[0])
      m_ien = wb_dat_i[NC-1:0];
    if (wr && hit && off == 0) begin
      if (wb_sel_i[0]) m_sel[idx] = wb_dat_i[4:0];
      if (wb_sel_i[1]) begin
        m_en[idx] = wb_dat_i[8];
        m_mode[idx] = wb_dat_i[9];
      end
    end
    m_prev = ev;
    m_ack = acc;
    m_irq = nirq;
    if (acc) exp_q.push_back(rd ? rv : 32'h0);
  endfunction

  // monitor: handshake, irq and scoreboard read data
  always @(negedge clk) begin
    if (rst_n) begin
      logic [31:0] e;
      checks++;
      if (wb_ack_o !== m_ack) begin
        errors++;
        $display("FAIL ack: got %b want %b", wb_ack_o, m_ack);
      end
      checks++;
      if (irq_o !== m_irq) begin
        errors++;
        $display("FAIL irq: got %b want %b", irq_o, m_irq);
      end
      checks++;
      if (wb_ack_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL ack_unexpected: got ack want none");
        end else begin
          e = exp_q.pop_front();
          if (wb_dat_o !== e) begin
            errors++;
            $display("FAIL rdata: got %h want %h", wb_dat_o, e);
          end
        end
      end else if (wb_dat_o !== 32'h0) begin
        errors++;
        $display("FAIL idle_data: got %h want 0", wb_dat_o);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    if (rand_ev) events_i = NE'($urandom);
  endtask

  task automatic bus(input bit we, input logic [7:0] a,
                     input logic [31:0] d, input logic [3:0] s);
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = we;
    wb_adr_i = a; wb_dat_i = d; wb_sel_i = s;
    tick();
    wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
    tick();
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    bus(1'b1, a, d, 4'hF);
  endtask

  task automatic rd(input logic [7:0] a);
    bus(1'b0, a, 32'h0, 4'hF);
  endtask

  task automatic pulses();
    repeat (3) begin
      events_i[3] = 1'b1;
      repeat (5) tick();
      events_i[3] = 1'b0;
      repeat (3) tick();
    end
  endtask

  initial begin
    wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
    wb_adr_i = 0; wb_dat_i = 0; wb_sel_i = 0;
    events_i = '0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // reset values
    rd(8'h00); rd(8'h04); rd(8'h40); rd(8'h44); rd(8'h48);

    // cycle count
    wr(8'h40, 32'h11F);
    wr(8'h00, 32'h1);
    repeat (100) tick();
    wr(8'h00, 32'h0);
    rd(8'h44); rd(8'h48);

    // edge then level counting on event 3
    wr(8'h50, 32'h303);
    wr(8'h00, 32'h1);
    pulses();
    wr(8'h00, 32'h0);
    rd(8'h54);
    wr(8'h54, 32'h0);
    wr(8'h50, 32'h103);
    wr(8'h00, 32'h1);
    pulses();
    wr(8'h00, 32'h0);
    rd(8'h54);

    // atomic 64-bit read across the carry
    wr(8'h64, 32'hFFFF_FFFE);
    wr(8'h68, 32'h0);
    wr(8'h60, 32'h11F);
    wr(8'h00, 32'h1);
    repeat (4) begin
      rd(8'h64); rd(8'h68); rd(8'h48);
    end
    wr(8'h00, 32'h0);

    // overflow with freeze and interrupt
    wr(8'h00, 32'h5);
    wr(8'h08, 32'h8);
    wr(8'h78, 32'hFFFF_FFFF);
    wr(8'h74, 32'hFFFF_FFFD);
    wr(8'h70, 32'h11F);
    repeat (10) tick();
    rd(8'h04); rd(8'h00); rd(8'h74); rd(8'h78);
    wr(8'h04, 32'h8);
    rd(8'h04);
    repeat (3) tick();

    // clear colliding with a wrap
    wr(8'h00, 32'h0);
    wr(8'h40, 32'h100);
    wr(8'h48, 32'hFFFF_FFFF);
    wr(8'h44, 32'hFFFF_FFFF);
    wr(8'h00, 32'h1);
    events_i[0] = 1'b1;
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 1;
    wb_adr_i = 8'h00; wb_dat_i = 32'h3; wb_sel_i = 4'hF;
    tick();
    events_i[0] = 1'b0;
    wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
    tick();
    rd(8'h44); rd(8'h48); rd(8'h04);
    wr(8'h00, 32'h0);

    // reset during a CFG0 write
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 1;
    wb_adr_i = 8'h40; wb_dat_i = 32'h31F; wb_sel_i = 4'hF;
    @(posedge clk);
    model_step();
    #1;
    rst_n = 1'b0;
    model_reset();
    exp_q.delete();
    #1;
    checks++;
    if (wb_ack_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_ack: got %b want 0", wb_ack_o);
    end
    @(negedge clk);
    wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
    tick(); tick();
    rst_n = 1'b1;
    rd(8'h40); rd(8'h00);

    // randomized traffic
    rand_ev = 1'b1;
    for (int n = 0; n < 500; n++) begin
      int op, c;
      logic [7:0] base;
      op = $urandom_range(0, 9);
      c = $urandom_range(0, NC - 1);
      base = 8'h40 + 8'(16 * c);
      case (op)
        0: bus(1'b1, base, $urandom, 4'($urandom));
        1: wr(8'h00, {29'd0, 1'($urandom),
                      ($urandom_range(0, 7) == 0),
                      ($urandom_range(0, 4) != 0)});
        2: wr(8'h04, $urandom);
        3: wr(8'h08, $urandom);
        4: bus(1'b1, base + 8'h4, $urandom, 4'($urandom));
        5: wr(base + 8'h8, ($urandom_range(0, 1) == 1) ?
                           32'hFFFF_FFFF : $urandom);
        6: begin
          wr(base + 8'h8, 32'hFFFF_FFFF);
          wr(base + 8'h4, 32'hFFFF_FFF0 | 32'($urandom_range(0, 15)));
        end
        7, 8: rd(8'($urandom_range(0, 255)) & 8'hFC);
        default: begin
          wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 0;
          wb_adr_i = 8'($urandom_range(0, 191)) & 8'hFC;
          wb_sel_i = 4'hF;
          repeat ($urandom_range(2, 6)) tick();
          wb_cyc_i = 0; wb_stb_i = 0;
          tick();
        end
      endcase
      repeat ($urandom_range(0, 3)) tick();
    end
    rand_ev = 1'b0;
    repeat (3) tick();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending: got %0d unacked want 0",
               exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
